traffic_sel_gen: RTL and testbench

- Producer of the `traffic_sel` input consumed by the signal control unit.
- Accumulates per-frame vehicle counts from the image-processing pipeline over a fixed window of frames and computes the window average.
- Classifies the average as light (0) or heavy (1) flow, using hysteresis and a multi-window confirmation.
- Applies a new classification only at a signal-cycle boundary, so the light controller never sees a mid-phase change.

---
 rtl/traffic_sel_gen.sv | 135 +++++++++++++
 tb/tb_traffic_sel_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_sel_gen.sv
// Averages per-frame vehicle counts over a window, classifies light/heavy flow
// with hysteresis and multi-window confirmation, and applies it at signal-cycle boundaries.
module traffic_sel_gen #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned WIN_LOG2 = 4,
    parameter int unsigned HI_TH    = 12,
    parameter int unsigned LO_TH    = 6,
    parameter int unsigned HOLD_WIN = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] car_cnt,
    input  logic             car_cnt_valid,
    input  logic             light_valid,
    output logic             traffic_sel,
    output logic             sel_valid,
    output logic [CNT_W-1:0] avg_cnt,
    output logic             avg_valid,
    output logic             pending_sel
);

    localparam int unsigned ACC_W = CNT_W + WIN_LOG2;
    localparam logic [CNT_W-1:0] HI   = CNT_W'(HI_TH);
    localparam logic [CNT_W-1:0] LO   = CNT_W'(LO_TH);
    localparam logic [3:0]       HOLD = 4'(HOLD_WIN);

    typedef enum logic {
        S_LIGHT = 1'b0,
        S_HEAVY = 1'b1
    } state_t;

    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [WIN_LOG2-1:0] frame_cnt;
    logic [3:0]          streak;
    logic [3:0]          streak_inc;
    logic [3:0]          streak_nxt;
    logic                pending_nxt;
    state_t              state;
    state_t              state_nxt;

    assign acc_sum    = acc + {{WIN_LOG2{1'b0}}, car_cnt};
    assign streak_inc = streak + 4'd1;

    // Window accumulation; the last frame's count is folded in directly so
    // the accumulator can clear in the same cycle the average is produced.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            frame_cnt <= '0;
            avg_cnt   <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (car_cnt_valid) begin
                frame_cnt <= frame_cnt + WIN_LOG2'(1);
                if (frame_cnt == '1) begin
                    avg_cnt   <= acc_sum[ACC_W-1:WIN_LOG2];
                    avg_valid <= 1'b1;
                    acc       <= '0;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_LIGHT;
            streak      <= '0;
            pending_sel <= 1'b0;
        end else begin
            state       <= state_nxt;
            streak      <= streak_nxt;
            pending_sel <= pending_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        streak_nxt  = streak;
        pending_nxt = pending_sel;
        if (avg_valid) begin
            case (state)
                S_LIGHT: begin
                    if (avg_cnt >= HI) begin
                        if (streak_inc == HOLD) begin
                            state_nxt   = S_HEAVY;
                            pending_nxt = 1'b1;
                            streak_nxt  = '0;
                        end else begin
                            streak_nxt = streak_inc;
                        end
                    end else begin
                        streak_nxt = '0;
                    end
                end
                S_HEAVY: begin
                    if (avg_cnt <= LO) begin
                        if (streak_inc == HOLD) begin
                            state_nxt   = S_LIGHT;
                            pending_nxt = 1'b0;
                            streak_nxt  = '0;
                        end else begin
                            streak_nxt = streak_inc;
                        end
                    end else begin
                        streak_nxt = '0;
                    end
                end
                default: begin
                    state_nxt  = S_LIGHT;
                    streak_nxt = '0;
                end
            endcase
        end
    end

    // Boundary sampling reads the registered pending_sel, so a classifier
    // update in the same cycle is deferred to the next boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            traffic_sel <= 1'b0;
            sel_valid   <= 1'b0;
        end else begin
            sel_valid <= 1'b0;
            if (light_valid) begin
                traffic_sel <= pending_sel;
                sel_valid   <= (pending_sel != traffic_sel);
            end
        end
    end

endmodule

// File: tb/tb_traffic_sel_gen.sv
// Scoreboard bench for traffic_sel_gen: stimulus pushes expected window averages,
// pending classifications and boundary changes; a monitor pops and compares them.
module tb_traffic_sel_gen;

    logic       clk;
    logic       reset;
    logic [7:0] car_cnt;
    logic       car_cnt_valid;
    logic       light_valid;
    logic       traffic_sel;
    logic       sel_valid;
    logic [7:0] avg_cnt;
    logic       avg_valid;
    logic       pending_sel;

    typedef struct {
        logic [7:0] avg;
        logic       pend;
    } win_exp_t;

    win_exp_t win_q[$];
    logic     sel_q[$];

    int tests_run = 0;
    int tests_failed = 0;

    traffic_sel_gen #(
        .CNT_W   (8),
        .WIN_LOG2(4),
        .HI_TH   (12),
        .LO_TH   (6),
        .HOLD_WIN(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .car_cnt      (car_cnt),
        .car_cnt_valid(car_cnt_valid),
        .light_valid  (light_valid),
        .traffic_sel  (traffic_sel),
        .sel_valid    (sel_valid),
        .avg_cnt      (avg_cnt),
        .avg_valid    (avg_valid),
        .pending_sel  (pending_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pending_sel is compared the cycle after each avg_valid.
    initial begin
        logic     pend_due;
        logic     pend_exp;
        win_exp_t w;
        logic     s;
        pend_due = 1'b0;
        pend_exp = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pend_due = 1'b0;
            end else begin
                if (pend_due) begin
                    check("pending_sel", int'(pending_sel), int'(pend_exp));
                    pend_due = 1'b0;
                end
                if (sel_valid) begin
                    if (sel_q.size() == 0) begin
                        check("sel_valid_unexpected", 1, 0);
                    end else begin
                        s = sel_q.pop_front();
                        check("traffic_sel_on_sel_valid", int'(traffic_sel), int'(s));
                    end
                end
                if (avg_valid) begin
                    if (win_q.size() == 0) begin
                        check("avg_valid_unexpected", 1, 0);
                    end else begin
                        w = win_q.pop_front();
                        check("avg_cnt", int'(avg_cnt), int'(w.avg));
                        pend_exp = w.pend;
                        pend_due = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frames(input int n, input logic [7:0] v);
        for (int i = 0; i < n; i++) begin
            car_cnt       = v;
            car_cnt_valid = 1'b1;
            tick();
        end
        car_cnt_valid = 1'b0;
    endtask

    // 16 frames alternating a/b; optional boundary strobe in the avg_valid cycle.
    task automatic send_window(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] exp_avg, input logic exp_pend,
                               input logic lv_at_avg);
        win_exp_t w;
        for (int i = 0; i < 16; i++) begin
            car_cnt       = (i % 2 == 1) ? b : a;
            car_cnt_valid = 1'b1;
            if (i == 15) begin
                w.avg  = exp_avg;
                w.pend = exp_pend;
                win_q.push_back(w);
            end
            tick();
        end
        car_cnt_valid = 1'b0;
        check("avg_valid_latency", int'(avg_valid), 1);
        if (lv_at_avg) light_valid = 1'b1;
        tick();
        light_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic boundary(input logic changes, input logic exp_sel);
        if (changes) sel_q.push_back(exp_sel);
        light_valid = 1'b1;
        tick();
        light_valid = 1'b0;
        check("traffic_sel_after_boundary", int'(traffic_sel), int'(exp_sel));
        tick();
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset         = 1'b0;
        car_cnt       = '0;
        car_cnt_valid = 1'b0;
        light_valid   = 1'b0;
        do_reset();

        // Averaging/truncation, then reset mid-window
        send_window(8'd13, 8'd14, 8'd13, 1'b0, 1'b0);
        send_frames(3, 8'd20);
        reset = 1'b0;
        #2;
        check("rst_traffic_sel", int'(traffic_sel), 0);
        check("rst_sel_valid", int'(sel_valid), 0);
        check("rst_avg_cnt", int'(avg_cnt), 0);
        check("rst_avg_valid", int'(avg_valid), 0);
        check("rst_pending_sel", int'(pending_sel), 0);
        tick();
        reset = 1'b1;
        tick();
        send_window(8'd20, 8'd20, 8'd20, 1'b0, 1'b0);
        send_window(8'd255, 8'd255, 8'd255, 1'b1, 1'b0);
        do_reset();

        // Confirmation and boundary application
        send_window(8'd15, 8'd15, 8'd15, 1'b0, 1'b0);
        send_window(8'd15, 8'd15, 8'd15, 1'b1, 1'b0);
        check("traffic_sel_before_boundary", int'(traffic_sel), 0);
        boundary(1'b1, 1'b1);

        // Hysteresis in heavy state
        send_window(8'd9, 8'd9, 8'd9, 1'b1, 1'b0);
        send_window(8'd9, 8'd9, 8'd9, 1'b1, 1'b0);
        send_window(8'd6, 8'd6, 8'd6, 1'b1, 1'b0);
        send_window(8'd6, 8'd6, 8'd6, 1'b0, 1'b0);
        boundary(1'b1, 1'b0);
        send_window(8'd15, 8'd15, 8'd15, 1'b0, 1'b0);
        send_window(8'd15, 8'd15, 8'd15, 1'b1, 1'b0);
        boundary(1'b1, 1'b1);
        send_window(8'd6, 8'd6, 8'd6, 1'b1, 1'b0);
        send_window(8'd15, 8'd15, 8'd15, 1'b1, 1'b0);
        send_window(8'd4, 8'd4, 8'd4, 1'b1, 1'b0);
        send_window(8'd4, 8'd4, 8'd4, 1'b0, 1'b0);
        boundary(1'b1, 1'b0);

        // Boundary coinciding with the classifier update
        send_window(8'd15, 8'd15, 8'd15, 1'b0, 1'b0);
        send_window(8'd15, 8'd15, 8'd15, 1'b1, 1'b1);
        check("traffic_sel_simultaneous", int'(traffic_sel), 0);
        boundary(1'b1, 1'b1);

        // Flip back and forth between boundaries
        send_window(8'd6, 8'd6, 8'd6, 1'b1, 1'b0);
        send_window(8'd6, 8'd6, 8'd6, 1'b0, 1'b0);
        boundary(1'b1, 1'b0);
        send_window(8'd15, 8'd15, 8'd15, 1'b0, 1'b0);
        send_window(8'd15, 8'd15, 8'd15, 1'b1, 1'b0);
        send_window(8'd6, 8'd6, 8'd6, 1'b1, 1'b0);
        send_window(8'd6, 8'd6, 8'd6, 1'b0, 1'b0);
        boundary(1'b0, 1'b0);
        boundary(1'b0, 1'b0);

        tick();
        tick();
        check("win_queue_drained", win_q.size(), 0);
        check("sel_queue_drained", sel_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
